ps2_key_decoder: RTL and testbench
==================================

# ps2_key_decoder

Receives the PS/2 keyboard serial stream and turns scan-code set 2 make/break sequences into held-key levels for the game modules. Drives the Alpha/Zulu/Sierra/Xray/Esc/Enter inputs of the flag game and its sibling games. Also exposes a per-code strobe for menus and debug.

## Interface
- TIMEOUT, 50000: Clock cycles without a PS2Clk falling edge before a partial frame is abandoned (1 ms at 50 MHz).
- Clock  in  1  system clock (50 MHz)
- Reset  in  1  synchronous, active-high
- PS2Clk  in  1  raw keyboard clock, asynchronous
- PS2Dat  in  1  raw keyboard data, asynchronous
- Alpha  out  1  level: A key (0x1C) held
- Zulu  out  1  level: Z key (0x1A) held
- Sierra  out  1  level: S key (0x1B) held
- Xray  out  1  level: X key (0x22) held
- Esc  out  1  level: Esc key (0x76) held
- Enter  out  1  level: Enter key (0x5A, non-extended) held
- KeyValid  out  1  one-cycle strobe per completed non-prefix code
- KeyCode  out  8  code byte, valid with KeyValid, held until next strobe
- KeyBreak  out  1  code was preceded by F0, valid with KeyValid
- KeyExt  out  1  code was preceded by E0, valid with KeyValid
- FrameErr  out  1  one-cycle strobe: bad parity, bad stop bit, or timeout

## Operation
- Synchronisers: PS2Clk and PS2Dat each pass through two flops; a third flop holds the previous synchronised clock. A fall is a cycle where synced clock = 0 and previous = 1; data is sampled from the synced data flop in that same cycle.
- Receiver FSM, all transitions only on a fall, except timeout:
  - IDLE: fall with data 0 -> DATA, bit count = 0. Fall with data 1 (bad start) -> stay IDLE, no error.
  - DATA: shift data in LSB first; after the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: if data = 1 and the 9 bits (data + parity) have odd parity, the byte is good; otherwise pulse FrameErr. Either way -> IDLE.
- Timeout: in any state other than IDLE, a counter counts cycles since the last fall. When it reaches TIMEOUT the FSM goes to IDLE, FrameErr pulses, and the byte is discarded. The counter clears on every fall and in IDLE.
- Decoder, on a good byte:
  - 0xF0: set brk.
  - 0xE0: set ext.
  - Any other byte: pulse KeyValid and load KeyCode/KeyBreak/KeyExt from the byte, brk and ext. If ext = 0 and the code matches a mapped key, set that key's level to ~brk. Then clear brk and ext.
- Extended codes (e.g. E0 5A keypad Enter, E0 F0 1C) never touch the key levels.
- FrameErr clears brk and ext. Key levels are unchanged.
- Key levels are independent. Any number can be 1 at once. A break for a key that is not held leaves it 0. A repeated make (typematic) leaves it 1.
- Unmapped codes only produce KeyValid.

## Timing
- Reset has priority over everything else. On the Reset cycle all outputs go to 0, the FSM goes to IDLE, brk, ext, bit count and timeout counter clear, and the synchroniser flops load 1 (idle bus).
- Reset mid-frame discards the partial byte. No FrameErr is produced for it.
- Pin-to-fall latency is 2–3 Clock cycles.
- KeyValid, key level updates and FrameErr are all registered. They appear in the cycle after the fall that samples the stop bit, or the cycle after timeout expiry.
- KeyCode, KeyBreak and KeyExt change only with KeyValid.
- Each PS2Clk low and high phase must last at least 4 Clock cycles. Faster edges are out of spec.
- Prefix bytes (F0, E0) produce no strobe. brk and ext persist indefinitely until the next good non-prefix byte, a FrameErr, or Reset.

## Test plan
- Send frame 0x1C (PS2Clk period 60 µs). Required: Alpha = 1, one KeyValid with KeyCode = 0x1C, KeyBreak = 0, KeyExt = 0; all other levels 0.
- Send 0x1C, 0x22, then F0 1C. Required: Alpha and Xray both 1, then Alpha = 0 with Xray still 1; last strobe has KeyCode = 0x1C, KeyBreak = 1.
- Send E0 5A, then E0 F0 5A, then 5A. Required: Enter stays 0 through both extended sequences (KeyExt = 1 on both strobes), then Enter = 1 with KeyExt = 0.
- Send 0x76 with the parity bit flipped. Required: one FrameErr pulse, no KeyValid, Esc = 0. Then send F0 and a corrupt frame, then 0x76. Required: Esc = 1 with KeyBreak = 0 (brk was cleared by the error).
- Send 5 bits, then hold the bus idle for TIMEOUT + 10 cycles. Required: exactly one FrameErr pulse, TIMEOUT cycles after the last fall. Then send a full 0x1B frame. Required: Sierra = 1.
- With Alpha held, assert Reset for 1 cycle in the middle of a 0x1A frame. Required: all outputs 0 in the following cycle, no strobes for the remaining bits, next full 0x1A frame sets Zulu = 1.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// PS/2 keyboard receiver and scan-code set 2 decoder. Synchronises the raw
// keyboard clock/data, frames 11-bit PS/2 packets, checks odd parity and the
// stop bit, and turns make/break sequences into held-key levels plus a
// per-code strobe for menus and debug.

module ps2_key_decoder #(
  parameter int TIMEOUT = 50000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       PS2Clk,
  input  logic       PS2Dat,
  output logic       Alpha,
  output logic       Zulu,
  output logic       Sierra,
  output logic       Xray,
  output logic       Esc,
  output logic       Enter,
  output logic       KeyValid,
  output logic [7:0] KeyCode,
  output logic       KeyBreak,
  output logic       KeyExt,
  output logic       FrameErr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [7:0] CODE_BREAK  = 8'hF0;
  localparam logic [7:0] CODE_EXT    = 8'hE0;
  localparam logic [7:0] CODE_ALPHA  = 8'h1C;
  localparam logic [7:0] CODE_ZULU   = 8'h1A;
  localparam logic [7:0] CODE_SIERRA = 8'h1B;
  localparam logic [7:0] CODE_XRAY   = 8'h22;
  localparam logic [7:0] CODE_ESC    = 8'h76;
  localparam logic [7:0] CODE_ENTER  = 8'h5A;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // Synchroniser chain; the idle bus is high, so these reset to 1
  logic ps2clk_meta_q, ps2clk_meta_d;
  logic ps2clk_sync_q, ps2clk_sync_d;
  logic ps2clk_prev_q, ps2clk_prev_d;
  logic ps2dat_meta_q, ps2dat_meta_d;
  logic ps2dat_sync_q, ps2dat_sync_d;

  // Receiver state
  rx_state_t        state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Decoder prefix memory and registered outputs
  logic       brk_q, brk_d;
  logic       ext_q, ext_d;
  logic       key_valid_q, key_valid_d;
  logic [7:0] key_code_q, key_code_d;
  logic       key_break_q, key_break_d;
  logic       key_ext_q, key_ext_d;
  logic       frame_err_q, frame_err_d;
  logic       alpha_q, alpha_d;
  logic       zulu_q, zulu_d;
  logic       sierra_q, sierra_d;
  logic       xray_q, xray_d;
  logic       esc_q, esc_d;
  logic       enter_q, enter_d;

  logic fall;
  logic byte_good;
  logic timeout_hit;

  assign fall = ps2clk_prev_q & ~ps2clk_sync_q;

  // Next-state logic: frame reception on keyboard clock falls, timeout
  // abandonment of partial frames, and make/break decoding of good bytes
  always_comb begin
    ps2clk_meta_d = PS2Clk;
    ps2clk_sync_d = ps2clk_meta_q;
    ps2clk_prev_d = ps2clk_sync_q;
    ps2dat_meta_d = PS2Dat;
    ps2dat_sync_d = ps2dat_meta_q;

    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    tmo_cnt_d   = tmo_cnt_q;
    brk_d       = brk_q;
    ext_d       = ext_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_break_d = key_break_q;
    key_ext_d   = key_ext_q;
    frame_err_d = 1'b0;
    alpha_d     = alpha_q;
    zulu_d      = zulu_q;
    sierra_d    = sierra_q;
    xray_d      = xray_q;
    esc_d       = esc_q;
    enter_d     = enter_q;
    byte_good   = 1'b0;

    if (state_q == ST_IDLE || fall) begin
      tmo_cnt_d = '0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    end

    timeout_hit = (state_q != ST_IDLE) && !fall &&
                  (tmo_cnt_q == CNT_W'(TIMEOUT - 1));

    if (timeout_hit) begin
      state_d     = ST_IDLE;
      tmo_cnt_d   = '0;
      frame_err_d = 1'b1;
      brk_d       = 1'b0;
      ext_d       = 1'b0;
    end else if (fall) begin
      case (state_q)
        ST_IDLE: begin
          if (!ps2dat_sync_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d   = {ps2dat_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          parity_d = ps2dat_sync_q;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (ps2dat_sync_q && (^{shift_q, parity_q})) begin
            byte_good = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            brk_d       = 1'b0;
            ext_d       = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (byte_good) begin
      if (shift_q == CODE_BREAK) begin
        brk_d = 1'b1;
      end else if (shift_q == CODE_EXT) begin
        ext_d = 1'b1;
      end else begin
        key_valid_d = 1'b1;
        key_code_d  = shift_q;
        key_break_d = brk_q;
        key_ext_d   = ext_q;
        if (!ext_q) begin
          case (shift_q)
            CODE_ALPHA:  alpha_d  = ~brk_q;
            CODE_ZULU:   zulu_d   = ~brk_q;
            CODE_SIERRA: sierra_d = ~brk_q;
            CODE_XRAY:   xray_d   = ~brk_q;
            CODE_ESC:    esc_d    = ~brk_q;
            CODE_ENTER:  enter_d  = ~brk_q;
            default: ;
          endcase
        end
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end
  end

  // State register; reset returns the bus view to idle-high and clears all else
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ps2clk_meta_q <= 1'b1;
      ps2clk_sync_q <= 1'b1;
      ps2clk_prev_q <= 1'b1;
      ps2dat_meta_q <= 1'b1;
      ps2dat_sync_q <= 1'b1;
      state_q       <= ST_IDLE;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      parity_q      <= 1'b0;
      tmo_cnt_q     <= '0;
      brk_q         <= 1'b0;
      ext_q         <= 1'b0;
      key_valid_q   <= 1'b0;
      key_code_q    <= 8'h00;
      key_break_q   <= 1'b0;
      key_ext_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      alpha_q       <= 1'b0;
      zulu_q        <= 1'b0;
      sierra_q      <= 1'b0;
      xray_q        <= 1'b0;
      esc_q         <= 1'b0;
      enter_q       <= 1'b0;
    end else begin
      ps2clk_meta_q <= ps2clk_meta_d;
      ps2clk_sync_q <= ps2clk_sync_d;
      ps2clk_prev_q <= ps2clk_prev_d;
      ps2dat_meta_q <= ps2dat_meta_d;
      ps2dat_sync_q <= ps2dat_sync_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      parity_q      <= parity_d;
      tmo_cnt_q     <= tmo_cnt_d;
      brk_q         <= brk_d;
      ext_q         <= ext_d;
      key_valid_q   <= key_valid_d;
      key_code_q    <= key_code_d;
      key_break_q   <= key_break_d;
      key_ext_q     <= key_ext_d;
      frame_err_q   <= frame_err_d;
      alpha_q       <= alpha_d;
      zulu_q        <= zulu_d;
      sierra_q      <= sierra_d;
      xray_q        <= xray_d;
      esc_q         <= esc_d;
      enter_q       <= enter_d;
    end
  end

  assign Alpha    = alpha_q;
  assign Zulu     = zulu_q;
  assign Sierra   = sierra_q;
  assign Xray     = xray_q;
  assign Esc      = esc_q;
  assign Enter    = enter_q;
  assign KeyValid = key_valid_q;
  assign KeyCode  = key_code_q;
  assign KeyBreak = key_break_q;
  assign KeyExt   = key_ext_q;
  assign FrameErr = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder
// Directed bench: drives PS/2 frames bit by bit and compares key levels,
// strobes and code fields against hand-computed values.

module tb_ps2_key_decoder;

  localparam int TB_TIMEOUT = 500;
  localparam int HALF       = 8;
  localparam int GAP        = 20;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       PS2Clk = 1'b1;
  logic       PS2Dat = 1'b1;
  logic       Alpha, Zulu, Sierra, Xray, Esc, Enter;
  logic       KeyValid;
  logic [7:0] KeyCode;
  logic       KeyBreak, KeyExt, FrameErr;

  logic [5:0] levels;
  assign levels = {Alpha, Zulu, Sierra, Xray, Esc, Enter};

  int tests_run = 0;
  int tests_failed = 0;

  int cyc = 0;
  int kv_total = 0;
  int fe_total = 0;
  int fe_cyc = 0;
  int fall_drive_cyc = 0;
  logic [7:0] last_code = 8'h00;
  logic       last_brk = 1'b0;
  logic       last_ext = 1'b0;

  ps2_key_decoder #(.TIMEOUT(TB_TIMEOUT)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .PS2Clk(PS2Clk),
    .PS2Dat(PS2Dat),
    .Alpha(Alpha),
    .Zulu(Zulu),
    .Sierra(Sierra),
    .Xray(Xray),
    .Esc(Esc),
    .Enter(Enter),
    .KeyValid(KeyValid),
    .KeyCode(KeyCode),
    .KeyBreak(KeyBreak),
    .KeyExt(KeyExt),
    .FrameErr(FrameErr)
  );

  // 50 MHz system clock
  always #10 Clock = ~Clock;

  // Free-running cycle index used to time the timeout pulse
  always @(posedge Clock) cyc <= cyc + 1;

  // Strobe monitor sampled on the falling system clock edge
  always @(negedge Clock) begin
    if (KeyValid) begin
      kv_total  = kv_total + 1;
      last_code = KeyCode;
      last_brk  = KeyBreak;
      last_ext  = KeyExt;
    end
    if (FrameErr) begin
      fe_total = fe_total + 1;
      fe_cyc   = cyc;
    end
  end

  function automatic logic [10:0] make_frame(input logic [7:0] b,
                                             input logic flip_par,
                                             input logic stop_bit);
    return {stop_bit, (~(^b)) ^ flip_par, b, 1'b0};
  endfunction

  // Shift out frame bits [first .. first+count-1], data set up while PS2Clk is high
  task automatic send_bits(input logic [10:0] fr, input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      @(negedge Clock);
      PS2Dat = fr[i];
      repeat (HALF) @(negedge Clock);
      PS2Clk = 1'b0;
      fall_drive_cyc = cyc;
      repeat (HALF) @(negedge Clock);
      PS2Clk = 1'b1;
    end
    repeat (HALF) @(negedge Clock);
    PS2Dat = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(make_frame(b, 1'b0, 1'b1), 0, 11);
    repeat (GAP) @(negedge Clock);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clock);
    tests_run++;
    if ({levels, KeyValid, KeyCode, KeyBreak, KeyExt, FrameErr} !== 19'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %b expected all zero",
               {levels, KeyValid, KeyCode, KeyBreak, KeyExt, FrameErr});
    end
    Reset = 1'b0;
    repeat (5) @(negedge Clock);
  endtask

  task automatic test_single_make();
    int kv0 = kv_total;
    send_byte(8'h1C);
    tests_run++;
    if (kv_total - kv0 !== 1) begin
      tests_failed++;
      $display("[TB] FAIL make_strobes: got %0d expected 1", kv_total - kv0);
    end
    tests_run++;
    if ({last_code, last_brk, last_ext} !== {8'h1C, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL make_fields: got code %h brk %b ext %b expected 1c 0 0",
               last_code, last_brk, last_ext);
    end
    tests_run++;
    if (levels !== 6'b100000) begin
      tests_failed++;
      $display("[TB] FAIL make_levels: got %b expected 100000", levels);
    end
    tests_run++;
    if (KeyCode !== 8'h1C) begin
      tests_failed++;
      $display("[TB] FAIL keycode_held: got %h expected 1c", KeyCode);
    end
  endtask

  task automatic test_multi_key();
    int kv0;
    send_byte(8'h22);
    tests_run++;
    if (levels !== 6'b100100) begin
      tests_failed++;
      $display("[TB] FAIL two_held: got %b expected 100100", levels);
    end
    kv0 = kv_total;
    send_byte(8'hF0);
    send_byte(8'h1C);
    tests_run++;
    if (kv_total - kv0 !== 1) begin
      tests_failed++;
      $display("[TB] FAIL break_strobes: got %0d expected 1", kv_total - kv0);
    end
    tests_run++;
    if ({levels, last_code, last_brk} !== {6'b000100, 8'h1C, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL break_alpha: got levels %b code %h brk %b expected 000100 1c 1",
               levels, last_code, last_brk);
    end
    send_byte(8'h22);
    tests_run++;
    if (levels !== 6'b000100) begin
      tests_failed++;
      $display("[TB] FAIL typematic: got %b expected 000100", levels);
    end
    send_byte(8'hF0);
    send_byte(8'h1A);
    tests_run++;
    if ({levels, last_code, last_brk} !== {6'b000100, 8'h1A, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL break_unheld: got levels %b code %h brk %b expected 000100 1a 1",
               levels, last_code, last_brk);
    end
  endtask

  task automatic test_extended();
    int kv0 = kv_total;
    send_byte(8'hE0);
    tests_run++;
    if (kv_total - kv0 !== 0) begin
      tests_failed++;
      $display("[TB] FAIL prefix_strobe: got %0d expected 0", kv_total - kv0);
    end
    send_byte(8'h5A);
    tests_run++;
    if ({levels, last_code, last_brk, last_ext} !== {6'b000100, 8'h5A, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL ext_make: got levels %b code %h brk %b ext %b expected 000100 5a 0 1",
               levels, last_code, last_brk, last_ext);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h5A);
    tests_run++;
    if ({levels, last_brk, last_ext} !== {6'b000100, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL ext_break: got levels %b brk %b ext %b expected 000100 1 1",
               levels, last_brk, last_ext);
    end
    send_byte(8'h5A);
    tests_run++;
    if ({levels, last_brk, last_ext} !== {6'b000101, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL enter_make: got levels %b brk %b ext %b expected 000101 0 0",
               levels, last_brk, last_ext);
    end
    tests_run++;
    if (kv_total - kv0 !== 3) begin
      tests_failed++;
      $display("[TB] FAIL ext_strobes: got %0d expected 3", kv_total - kv0);
    end
  endtask

  task automatic test_frame_error();
    int kv0 = kv_total;
    int fe0 = fe_total;
    send_bits(make_frame(8'h76, 1'b1, 1'b1), 0, 11);
    repeat (GAP) @(negedge Clock);
    tests_run++;
    if ({fe_total - fe0, kv_total - kv0} !== {32'd1, 32'd0} || levels !== 6'b000101) begin
      tests_failed++;
      $display("[TB] FAIL parity_err: got fe %0d kv %0d levels %b expected 1 0 000101",
               fe_total - fe0, kv_total - kv0, levels);
    end
    fe0 = fe_total;
    send_byte(8'hF0);
    send_bits(make_frame(8'h1C, 1'b0, 1'b0), 0, 11);
    repeat (GAP) @(negedge Clock);
    tests_run++;
    if (fe_total - fe0 !== 1) begin
      tests_failed++;
      $display("[TB] FAIL stop_err: got %0d expected 1", fe_total - fe0);
    end
    send_byte(8'h76);
    tests_run++;
    if ({levels, last_code, last_brk} !== {6'b000111, 8'h76, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL err_clears_brk: got levels %b code %h brk %b expected 000111 76 0",
               levels, last_code, last_brk);
    end
  endtask

  task automatic test_timeout();
    int kv0 = kv_total;
    int fe0 = fe_total;
    int f0;
    send_bits(make_frame(8'h55, 1'b0, 1'b1), 0, 5);
    f0 = fall_drive_cyc;
    repeat (TB_TIMEOUT + 10) @(negedge Clock);
    tests_run++;
    if (fe_total - fe0 !== 1 || kv_total - kv0 !== 0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_count: got fe %0d kv %0d expected 1 0",
               fe_total - fe0, kv_total - kv0);
    end
    tests_run++;
    if (fe_cyc < f0 + 2 + TB_TIMEOUT || fe_cyc > f0 + 3 + TB_TIMEOUT) begin
      tests_failed++;
      $display("[TB] FAIL timeout_time: got %0d cycles after pin fall, expected %0d..%0d",
               fe_cyc - f0, 2 + TB_TIMEOUT, 3 + TB_TIMEOUT);
    end
    send_byte(8'h1B);
    tests_run++;
    if (levels !== 6'b001111) begin
      tests_failed++;
      $display("[TB] FAIL after_timeout: got %b expected 001111", levels);
    end
  endtask

  task automatic test_reset_midframe();
    logic [10:0] fr;
    int kv0;
    int fe0;
    fr = make_frame(8'h1A, 1'b0, 1'b1);
    send_byte(8'h1C);
    tests_run++;
    if (levels !== 6'b101111) begin
      tests_failed++;
      $display("[TB] FAIL alpha_before_reset: got %b expected 101111", levels);
    end
    send_bits(fr, 0, 5);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    tests_run++;
    if ({levels, KeyValid, KeyCode, KeyBreak, KeyExt, FrameErr} !== 19'd0) begin
      tests_failed++;
      $display("[TB] FAIL midframe_reset: got %b expected all zero",
               {levels, KeyValid, KeyCode, KeyBreak, KeyExt, FrameErr});
    end
    kv0 = kv_total;
    fe0 = fe_total;
    send_bits(fr, 5, 6);
    tests_run++;
    if (kv_total - kv0 !== 0 || fe_total - fe0 !== 0) begin
      tests_failed++;
      $display("[TB] FAIL tail_strobes: got kv %0d fe %0d expected 0 0",
               kv_total - kv0, fe_total - fe0);
    end
    repeat (TB_TIMEOUT + 20) @(negedge Clock);
    send_byte(8'h1A);
    tests_run++;
    if ({levels, last_code} !== {6'b010000, 8'h1A}) begin
      tests_failed++;
      $display("[TB] FAIL zulu_after_reset: got levels %b code %h expected 010000 1a",
               levels, last_code);
    end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_single_make();
    test_multi_key();
    test_extended();
    test_frame_error();
    test_timeout();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
